branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 132 +++++++++++++
 tb/tb_branch_resolver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Branch resolver: queues decode-stage predictions, compares them against the
// execute-stage outcomes, and issues flush/redirect pulses and predictor updates.
module branch_resolver #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        flush_d,
  output logic        flush_e,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic        upd_taken,
  output logic [31:0] upd_target,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt,
  output logic        overflow_err,
  output logic        seq_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_RUN, S_RECOVER} state_t;

  state_t        state_q;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic          taken_mem_q [DEPTH];
  logic [31:0]   tgt_mem_q   [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic        empty, full;
  logic [31:0] cmp_pc, cmp_tgt, correct_pc;
  logic        cmp_taken;
  logic        mispredict, seq_hit, ovf_hit;
  logic        pop, push;

  // Head comparison, mispredict detection and queue push/pop decisions
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_CNT);
    // An orphan resolution is compared against a not-taken fall-through entry
    cmp_pc     = empty ? res_pc          : pc_mem_q[rd_ptr_q];
    cmp_taken  = empty ? 1'b0            : taken_mem_q[rd_ptr_q];
    cmp_tgt    = empty ? res_pc + 32'd4  : tgt_mem_q[rd_ptr_q];
    seq_hit    = res_valid && (empty || (cmp_pc != res_pc));
    mispredict = res_valid && ((cmp_taken != res_taken) ||
                               (res_taken && (cmp_tgt != res_target)) ||
                               (cmp_pc != res_pc));
    correct_pc = res_taken ? res_target : res_pc + 32'd4;
    pop        = res_valid && !empty;
    push       = pred_valid && (state_q == S_RUN) && !mispredict && (!full || pop);
    ovf_hit    = pred_valid && (state_q == S_RUN) && full && !pop;
    count_d    = count_q;
    if (mispredict) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Prediction storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pred_pc;
      taken_mem_q[wr_ptr_q] <= pred_taken;
      tgt_mem_q[wr_ptr_q]   <= pred_target;
    end
  end

  // Control state, queue pointers, registered pulses, counters and sticky errors
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_RUN;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      flush_d        <= 1'b0;
      flush_e        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      overflow_err   <= 1'b0;
      seq_err        <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN:     state_q <= mispredict ? S_RECOVER : S_RUN;
        S_RECOVER: state_q <= S_RUN;
        default:   state_q <= S_RUN;
      endcase
      // Mispredict squashes every younger entry, so pointers restart at zero
      if (mispredict) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      count_q        <= count_d;
      flush_d        <= mispredict;
      flush_e        <= mispredict;
      redirect_valid <= mispredict;
      redirect_pc    <= mispredict ? correct_pc : '0;
      upd_valid      <= res_valid;
      upd_pc         <= res_valid ? res_pc : '0;
      upd_taken      <= res_valid && res_taken;
      upd_target     <= res_valid ? res_target : '0;
      if (res_valid)  branch_cnt     <= branch_cnt + 32'd1;
      if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
      if (ovf_hit)    overflow_err   <= 1'b1;
      if (seq_hit)    seq_err        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_branch_resolver;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0, pred_taken = 1'b0;
  logic [31:0] pred_pc = '0, pred_target = '0;
  logic        res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] res_pc = '0, res_target = '0;
  logic        flush_d, flush_e, redirect_valid, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target, branch_cnt, mispredict_cnt;
  logic        overflow_err, seq_err;

  branch_resolver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .flush_d(flush_d), .flush_e(flush_e), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt),
    .overflow_err(overflow_err), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } entry_t;

  entry_t      mq[$];
  entry_t      m_head;
  bit          m_have, m_mis, m_recover;
  logic        e_flush, e_upd_valid, e_upd_taken, e_ovf, e_seq;
  logic [31:0] e_redir_pc, e_upd_pc, e_upd_target, e_branch, e_mis;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_recover = 1'b0;
      e_flush = 0; e_redir_pc = 0; e_upd_valid = 0; e_upd_pc = 0; e_upd_taken = 0;
      e_upd_target = 0; e_branch = 0; e_mis = 0; e_ovf = 0; e_seq = 0;
    end else begin
      m_mis = 1'b0;
      e_flush = 0; e_redir_pc = 0; e_upd_valid = 0; e_upd_pc = 0; e_upd_taken = 0; e_upd_target = 0;
      if (res_valid) begin
        m_have = (mq.size() != 0);
        if (m_have) m_head = mq[0];
        else begin
          m_head.pc = res_pc; m_head.taken = 1'b0; m_head.tgt = res_pc + 32'd4;
        end
        if (!m_have || m_head.pc != res_pc) e_seq = 1;
        m_mis = (m_head.taken != res_taken) || (res_taken && m_head.tgt != res_target) ||
                (m_head.pc != res_pc) || (!m_have && res_taken);
        e_branch = e_branch + 1;
        e_upd_valid = 1; e_upd_pc = res_pc; e_upd_taken = res_taken; e_upd_target = res_target;
        if (m_mis) begin
          e_mis = e_mis + 1;
          e_flush = 1;
          e_redir_pc = res_taken ? res_target : res_pc + 32'd4;
        end
      end
      if (m_mis) mq.delete();
      else begin
        if (res_valid && m_have) void'(mq.pop_front());
        if (pred_valid && !m_recover) begin
          if (mq.size() < DEPTH) mq.push_back('{pred_pc, pred_taken, pred_target});
          else e_ovf = 1;
        end
      end
      m_recover = m_mis && !m_recover;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("flush_d", {31'd0, flush_d}, {31'd0, e_flush});
      chk("flush_e", {31'd0, flush_e}, {31'd0, e_flush});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_flush});
      chk("redirect_pc", redirect_pc, e_redir_pc);
      chk("upd_valid", {31'd0, upd_valid}, {31'd0, e_upd_valid});
      chk("upd_pc", upd_pc, e_upd_pc);
      chk("upd_taken", {31'd0, upd_taken}, {31'd0, e_upd_taken});
      chk("upd_target", upd_target, e_upd_target);
      chk("branch_cnt", branch_cnt, e_branch);
      chk("mispredict_cnt", mispredict_cnt, e_mis);
      chk("overflow_err", {31'd0, overflow_err}, {31'd0, e_ovf});
      chk("seq_err", {31'd0, seq_err}, {31'd0, e_seq});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rst,
                      input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                      input logic rv, input logic [31:0] rpc, input logic rt, input logic [31:0] rtg);
    @(negedge clk);
    reset = rst;
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg;
    @(posedge clk);
    #1;
    reset = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_flush_d", {31'd0, flush_d}, 32'd0);

    // Correct prediction
    step(0, 1, 32'h14, 1, 32'h40, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h14, 1, 32'h40);
    chk("ok_flush_d", {31'd0, flush_d}, 32'd0);
    chk("ok_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("ok_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("ok_upd_pc", upd_pc, 32'h14);
    chk("ok_branch_cnt", branch_cnt, 32'd1);
    chk("ok_mispredict_cnt", mispredict_cnt, 32'd0);

    // Taken mispredict, then a pred_valid during recovery must be ignored
    step(0, 1, 32'h14, 0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h14, 1, 32'h40);
    chk("tm_flush_d", {31'd0, flush_d}, 32'd1);
    chk("tm_flush_e", {31'd0, flush_e}, 32'd1);
    chk("tm_redirect_pc", redirect_pc, 32'h40);
    chk("tm_mispredict_cnt", mispredict_cnt, 32'd1);
    step(0, 1, 32'h20, 1, 32'h80, 0, 0, 0, 0);
    chk("tm_pulse_once", {31'd0, flush_d}, 32'd0);
    step(0, 0, 0, 0, 0, 1, 32'h20, 0, 32'h24);
    chk("tm_ignored_seq", {31'd0, seq_err}, 32'd1);
    chk("tm_ignored_flush", {31'd0, flush_d}, 32'd0);
    chk("tm_branch_cnt", branch_cnt, 32'd3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst2_seq_err", {31'd0, seq_err}, 32'd0);

    // Not-taken mispredict with PC wrap
    step(0, 1, 32'hFFFF_FFFC, 1, 32'h8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    chk("wrap_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    idle();

    // Queue limits
    for (int i = 0; i < 4; i++) step(0, 1, 32'h100 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0);
    step(0, 1, 32'h110, 0, 32'h0, 1, 32'h100, 0, 32'h0);
    chk("full_pushpop_ovf", {31'd0, overflow_err}, 32'd0);
    chk("full_pushpop_flush", {31'd0, flush_d}, 32'd0);
    chk("full_pushpop_upd_pc", upd_pc, 32'h100);
    step(0, 1, 32'h114, 0, 32'h0, 0, 0, 0, 0);
    chk("overflow_err", {31'd0, overflow_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, 32'h104 + 32'(4 * i), 0, 32'h0);
      chk("drain_flush", {31'd0, flush_d}, 32'd0);
      chk("drain_seq", {31'd0, seq_err}, 32'd0);
    end
    step(0, 0, 0, 0, 0, 1, 32'h114, 0, 32'h0);
    chk("dropped_seq", {31'd0, seq_err}, 32'd1);

    // Orphan taken resolution mispredicts, then reset during recovery
    step(0, 0, 0, 0, 0, 1, 32'h200, 1, 32'h300);
    chk("orphan_flush", {31'd0, flush_d}, 32'd1);
    chk("orphan_redirect_pc", redirect_pc, 32'h300);
    step(1, 1, 32'h400, 1, 32'h500, 1, 32'h200, 1, 32'h300);
    chk("rrec_flush_d", {31'd0, flush_d}, 32'd0);
    chk("rrec_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("rrec_branch_cnt", branch_cnt, 32'd0);
    chk("rrec_mispredict_cnt", mispredict_cnt, 32'd0);
    chk("rrec_seq_err", {31'd0, seq_err}, 32'd0);
    chk("rrec_overflow_err", {31'd0, overflow_err}, 32'd0);
    idle();
    chk("rrec_after_flush", {31'd0, flush_d}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 249) == 0);
      pred_valid = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
      pred_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'(4 * $urandom_range(0, 7));
      pred_taken = $urandom_range(0, 1) == 1;
      pred_target = ($urandom_range(0, 1) == 1) ? $urandom : 32'h2000 + 32'(4 * $urandom_range(0, 3));
      res_valid = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      if (mq.size() != 0 && $urandom_range(0, 7) != 0) begin
        res_pc = ($urandom_range(0, 15) == 0) ? mq[0].pc + 32'd4 : mq[0].pc;
        res_taken = ($urandom_range(0, 5) == 0) ? ~mq[0].taken : mq[0].taken;
        res_target = ($urandom_range(0, 5) == 0) ? $urandom : mq[0].tgt;
      end else begin
        res_pc = 32'h1000 + 32'(4 * $urandom_range(0, 7));
        res_taken = $urandom_range(0, 1) == 1;
        res_target = $urandom;
      end
    end
    @(negedge clk);
    reset = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
